mem_arbiter_rr: RTL
===================

# mem_arbiter_rr

Parametrised byte-serial memory arbiter between `NCH` requesting channels (fetcher, load/store buffers, future prefetch/DMA) and the single-port, one-byte-wide `ram`. Each channel has a one-entry request slot; pending writes win over reads, ties are broken round-robin. IO writes are throttled by `io_buffer_full` and paced at one byte every two cycles. On rollback, loads on selected channels are flushed or aborted while stores always complete.

## Interface
- `NCH`, 2: number of channels, 1..8; channel 0 is lowest index.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: maximum transfer width in bits, multiple of 8; `MAXB` = `DATA_W`/8.
- `IO_BIT`, 17: address is IO when `addr[IO_BIT:IO_BIT-1]` == 2'b11.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `io_buffer_full` in 1: IO sink cannot accept a byte.
- `ram_data_in` in 8: read byte; valid the second cycle after its address is driven.
- `ram_data_out` out 8: write byte.
- `ram_address_out` out `ADDR_W`: byte address.
- `ram_rw_signal_out` out 1: 1 = write, 0 = read.
- `rollback_in` in 1: pipeline flush.
- `flush_mask` in `NCH`: channels whose reads are dropped on rollback.
- `req_valid` in `NCH`: request strobe per channel.
- `req_ready` out `NCH`: channel slot empty.
- `req_rw` in `NCH`: 1 = store, 0 = load.
- `req_addr` in `NCH*ADDR_W`: start address, channel c at `[c*ADDR_W +: ADDR_W]`.
- `req_size` in `NCH*3`: byte count.
- `req_wdata` in `NCH*DATA_W`: store data, little-endian.
- `done` out `NCH`: one-cycle completion pulse, at most one bit set.
- `rdata` out `DATA_W`: load result, valid while `done` is high.

## Operation
- Accept: a request is accepted on a cycle edge where `req_valid[c]` & `req_ready[c]`; this fills slot c. Requests with `req_valid` high while the slot is full are ignored; the requester must hold `req_valid`.
- Slot lifetime: the slot clears on the grant edge. A new request may therefore be accepted while the previous one is in flight.
- Size rules: `req_size` 0 is treated as 1; values above `MAXB` are treated as `MAXB`.
- Byte order: byte k goes to `addr+k`, with the sum taken mod 2^`ADDR_W`.
- States: IDLE, RD_WAIT, RD_CAP, WR, WR_WAIT, FINISH.
- Arbitration (IDLE only):
  - Eligible writes are full slots with rw=1, excluding IO writes while `io_buffer_full` is high.
  - If any eligible write exists, grant round-robin among them; otherwise grant round-robin among pending reads.
  - Round-robin search starts at `rr_ptr`; after a grant, `rr_ptr` becomes granted index + 1 mod `NCH`.
  - With nothing to grant, stay in IDLE.
- Read transfer:
  - The grant edge drives byte-0 address with rw=0, then moves to RD_WAIT.
  - RD_WAIT always moves to RD_CAP.
  - RD_CAP captures `ram_data_in` into byte k. After the last byte it goes to FINISH; otherwise it drives address k+1 and returns to RD_WAIT.
- Write transfer:
  - The grant edge drives byte 0 with rw=1.
  - WR drives the next byte on each edge.
  - For IO addresses, each byte is followed by one WR_WAIT cycle with rw=0.
  - After the last byte, go to FINISH and return rw to 0. rw is high only in cycles that carry a new byte, so no byte is written twice.
- FINISH: pulse `done[c]`. `rdata` carries the captured bytes zero-extended above the size (0 for stores). Return to IDLE.
- Rollback (`rollback_in` high at an edge):
  - Clear pending read slots of channels with `flush_mask` set.
  - An in-flight read on a flagged channel aborts to IDLE with no `done`, and rw is 0.
  - In-flight writes and pending writes continue.
  - In the same cycle, read requests on flagged channels are not accepted; all other requests are accepted normally.
  - Arbitration does not grant on a rollback edge.

## Timing
- Reset values:
  - All outputs 0; `req_ready` all 1.
  - `rr_ptr` 0, state IDLE, slots empty.
- Grant: earliest on the edge after acceptance (edge A+1).
- Read of S bytes granted at edge G: `done` is high in the cycle after edge G+2S+1.
- Non-IO write of S bytes: `done` is high after edge G+S+1.
- IO write of S bytes: `done` is high after edge G+2S.
- Back-to-back: the next grant happens on the edge that leaves FINISH's successor IDLE cycle. Every transfer therefore costs one IDLE cycle.
- A reset assertion mid-transfer abandons it immediately; no `done` is produced.

## Test plan
- Read, NCH=2: ch0 load addr 0x100, size 4, ram bytes 11,22,33,44 → single `done[0]` 10 cycles after grant, `rdata`=0x44332211.
- Arbitration: ch0 load and ch1 store (0x200, size 2, 0xBEEF) accepted the same cycle → store granted first; ram sees 0x200=EF, 0x201=BE, each rw=1 for exactly one cycle; then the load completes.
- Round-robin: both channels issue loads continuously for 6 grants → grants alternate 0,1,0,1,…
- IO throttle: ch1 store to 0x30000, size 1, with `io_buffer_full`=1 for 5 cycles → no grant; grant on the first edge after it drops; `done` 2 edges later.
- Rollback: ch0 load size 4 in RD_CAP of byte 1 with `flush_mask`=01 → no `done[0]`, IDLE next cycle; a pending ch1 store still completes.
- Reset mid-write: drop `rst` during byte 1 of a size-4 store → outputs 0 asynchronously, `req_ready`=all 1.

Source files
------------

// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - byte-serial round-robin memory arbiter, writes before reads
// One request slot per channel; a single sequencer moves one byte at a time to the RAM port.
module mem_arbiter_rr #(
  parameter int NCH    = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IO_BIT = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  io_buffer_full,
  input  logic [7:0]            ram_data_in,
  output logic [7:0]            ram_data_out,
  output logic [ADDR_W-1:0]     ram_address_out,
  output logic                  ram_rw_signal_out,
  input  logic                  rollback_in,
  input  logic [NCH-1:0]        flush_mask,
  input  logic [NCH-1:0]        req_valid,
  output logic [NCH-1:0]        req_ready,
  input  logic [NCH-1:0]        req_rw,
  input  logic [NCH*ADDR_W-1:0] req_addr,
  input  logic [NCH*3-1:0]      req_size,
  input  logic [NCH*DATA_W-1:0] req_wdata,
  output logic [NCH-1:0]        done,
  output logic [DATA_W-1:0]     rdata
);

  localparam int MAXB = DATA_W / 8;
  localparam int PW   = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_CAP, WR, WR_WAIT, FINISH} state_t;

  logic [NCH-1:0]    slot_full, slot_rw, slot_io;
  logic [ADDR_W-1:0] slot_addr  [NCH];
  logic [3:0]        slot_size  [NCH];
  logic [DATA_W-1:0] slot_wdata [NCH];

  state_t            state;
  logic [PW-1:0]     rr_ptr, cur_ch, gnt_idx;
  logic              cur_rw, cur_io, gnt_vld, grant_now, last_byte;
  logic [ADDR_W-1:0] cur_addr;
  logic [3:0]        cur_size, idx, nidx;
  logic [DATA_W-1:0] xbuf;
  logic [NCH-1:0]    wr_elig, rd_pend, cand;

  function automatic logic [3:0] eff_size(input logic [2:0] s);
    if (s == 3'd0) return 4'd1;
    if (int'(s) > MAXB) return 4'(MAXB);
    return {1'b0, s};
  endfunction

  assign req_ready = ~slot_full;
  assign nidx      = idx + 4'd1;
  assign last_byte = (idx == cur_size - 4'd1);
  assign grant_now = (state == IDLE) && !rollback_in && gnt_vld;

  // Writes take precedence; within the chosen class search upward from rr_ptr.
  always_comb begin
    wr_elig = slot_full & slot_rw & ~(slot_io & {NCH{io_buffer_full}});
    rd_pend = slot_full & ~slot_rw;
    cand    = (|wr_elig) ? wr_elig : rd_pend;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (cand[(int'(rr_ptr) + i) % NCH]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'((int'(rr_ptr) + i) % NCH);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_full <= '0;
      slot_rw   <= '0;
      slot_io   <= '0;
      for (int c = 0; c < NCH; c++) begin
        slot_addr[c]  <= '0;
        slot_size[c]  <= '0;
        slot_wdata[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (slot_full[c]) begin
          if ((grant_now && int'(gnt_idx) == c) ||
              (rollback_in && flush_mask[c] && !slot_rw[c]))
            slot_full[c] <= 1'b0;
        end else if (req_valid[c] && !(rollback_in && flush_mask[c] && !req_rw[c])) begin
          slot_full[c]  <= 1'b1;
          slot_rw[c]    <= req_rw[c];
          slot_io[c]    <= (req_addr[c*ADDR_W + IO_BIT -: 2] == 2'b11);
          slot_addr[c]  <= req_addr[c*ADDR_W +: ADDR_W];
          slot_size[c]  <= eff_size(req_size[c*3 +: 3]);
          slot_wdata[c] <= req_wdata[c*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      rr_ptr            <= '0;
      cur_ch            <= '0;
      cur_rw            <= 1'b0;
      cur_io            <= 1'b0;
      cur_addr          <= '0;
      cur_size          <= '0;
      idx               <= '0;
      xbuf              <= '0;
      ram_data_out      <= '0;
      ram_address_out   <= '0;
      ram_rw_signal_out <= 1'b0;
      done              <= '0;
      rdata             <= '0;
    end else begin
      done  <= '0;
      rdata <= '0;
      // A flushed load is dropped wherever it is; stores are never interrupted.
      if (rollback_in && state != IDLE && !cur_rw && flush_mask[cur_ch]) begin
        state             <= IDLE;
        ram_rw_signal_out <= 1'b0;
      end else begin
        case (state)
          IDLE: if (grant_now) begin
            cur_ch            <= gnt_idx;
            cur_rw            <= slot_rw[gnt_idx];
            cur_io            <= slot_io[gnt_idx];
            cur_addr          <= slot_addr[gnt_idx];
            cur_size          <= slot_size[gnt_idx];
            idx               <= '0;
            rr_ptr            <= (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + PW'(1);
            ram_address_out   <= slot_addr[gnt_idx];
            ram_rw_signal_out <= slot_rw[gnt_idx];
            xbuf              <= slot_rw[gnt_idx] ? slot_wdata[gnt_idx] : '0;
            if (slot_rw[gnt_idx]) ram_data_out <= slot_wdata[gnt_idx][7:0];
            state             <= slot_rw[gnt_idx] ? WR : RD_WAIT;
          end
          RD_WAIT: state <= RD_CAP;
          RD_CAP: begin
            xbuf[{idx, 3'b000} +: 8] <= ram_data_in;
            if (last_byte) begin
              state <= FINISH;
            end else begin
              idx             <= nidx;
              ram_address_out <= cur_addr + ADDR_W'(nidx);
              state           <= RD_WAIT;
            end
          end
          WR: begin
            if (last_byte || cur_io) begin
              ram_rw_signal_out <= 1'b0;
              state             <= last_byte ? FINISH : WR_WAIT;
            end else begin
              idx             <= nidx;
              ram_address_out <= cur_addr + ADDR_W'(nidx);
              ram_data_out    <= xbuf[{nidx, 3'b000} +: 8];
            end
          end
          WR_WAIT: begin
            idx               <= nidx;
            ram_address_out   <= cur_addr + ADDR_W'(nidx);
            ram_data_out      <= xbuf[{nidx, 3'b000} +: 8];
            ram_rw_signal_out <= 1'b1;
            state             <= WR;
          end
          FINISH: begin
            done[cur_ch] <= 1'b1;
            rdata        <= cur_rw ? '0 : xbuf;
            state        <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
